// File: rtl/lzx_decoder_scan_pkg.sv
// Shared encodings for the one-cold direct/scan decoder.
package lzx_decoder_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2,
      ST_PAUSE  = 2'd3
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/lzx_decoder_scan_dwell.sv
// Dwell counter: counts inc pulses 0..DWELL-1 and wraps; clr has priority.
module lzx_dwell_counter #(
   parameter int unsigned DWELL = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic done_o
);

   localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign done_o = (cnt_q == CntW'(DWELL - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = done_o ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lzx_decoder_scan.sv
// SEL_W-to-2^SEL_W one-cold decoder with registered outputs and an
// auto-scan mode that dwells DWELL cycles per output, with pause/resume.
module lzx_decoder_scan
   import lzx_decoder_scan_pkg::*;
#(
   parameter int unsigned SEL_W = 2,
   parameter int unsigned DWELL = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   en_i,
   input  logic                   mode_i,
   input  logic [SEL_W-1:0]       sel_i,
   output logic [(1<<SEL_W)-1:0]  y_o,
   output logic [SEL_W-1:0]       idx_o,
   output logic                   wrap_o
);

   localparam int unsigned N = 1 << SEL_W;
   localparam logic [N-1:0] One = {{(N-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [N-1:0]     y_q, y_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic             wrap_q, wrap_d;
   logic             cnt_clr, cnt_inc, cnt_done;

   lzx_dwell_counter #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .done_o (cnt_done)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en_i) begin
         state_d = (state_q == ST_SCAN || state_q == ST_PAUSE) ? ST_PAUSE : ST_IDLE;
      end else if (mode_i == MODE_DIRECT) begin
         state_d = ST_DIRECT;
      end else begin
         state_d = ST_SCAN;
      end
   end

   // Outputs depend on the transition: SCAN entry differs by where it came from.
   always_comb begin
      y_d     = '1;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      unique case (state_d)
         ST_DIRECT: begin
            idx_d = sel_i;
            y_d   = ~(One << sel_i);
         end
         ST_SCAN: begin
            if (state_q == ST_SCAN) begin
               cnt_inc = 1'b1;
               if (cnt_done) begin
                  idx_d  = idx_q + SEL_W'(1);
                  wrap_d = &idx_q;
               end
               y_d = ~(One << idx_d);
            end else if (state_q == ST_PAUSE) begin
               y_d = ~(One << idx_q);
            end else begin
               idx_d   = '0;
               cnt_clr = 1'b1;
               y_d     = ~One;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         y_q    <= '1;
         idx_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         y_q    <= y_d;
         idx_q  <= idx_d;
         wrap_q <= wrap_d;
      end
   end

   assign y_o    = y_q;
   assign idx_o  = idx_q;
   assign wrap_o = wrap_q;

endmodule

// File: tb/tb_lzx_decoder_scan.sv
// Directed bench: 2-bit/DWELL=3 instance and 3-bit/DWELL=1 instance.
module tb_lzx_decoder_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_en, a_mode;
   logic [1:0] a_sel;
   logic [3:0] a_y;
   logic [1:0] a_idx;
   logic       a_wrap;
   logic       b_en, b_mode;
   logic [2:0] b_sel;
   logic [7:0] b_y;
   logic [2:0] b_idx;
   logic       b_wrap;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lzx_decoder_scan #(
      .SEL_W (2),
      .DWELL (3)
   ) u_a (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (a_en),
      .mode_i (a_mode),
      .sel_i  (a_sel),
      .y_o    (a_y),
      .idx_o  (a_idx),
      .wrap_o (a_wrap)
   );

   lzx_decoder_scan #(
      .SEL_W (3),
      .DWELL (1)
   ) u_b (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (b_en),
      .mode_i (b_mode),
      .sel_i  (b_sel),
      .y_o    (b_y),
      .idx_o  (b_idx),
      .wrap_o (b_wrap)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [3:0] y, input logic [1:0] idx,
                        input logic wrap);
      chk({tag, ".y"}, 32'(a_y), 32'(y));
      chk({tag, ".idx"}, 32'(a_idx), 32'(idx));
      chk({tag, ".wrap"}, 32'(a_wrap), 32'(wrap));
   endtask

   initial begin
      logic [3:0] ea;
      logic [7:0] eb;
      rst = 1'b1; a_en = 1'b0; a_mode = 1'b0; a_sel = 2'd0;
      b_en = 1'b0; b_mode = 1'b0; b_sel = 3'd0;
      tick();
      chk_a("reset", 4'b1111, 2'd0, 1'b0);
      chk("reset.b_y", 32'(b_y), 32'hff);
      rst = 1'b0;

      // DIRECT decode, one cycle latency
      a_en = 1'b1; a_mode = 1'b0;
      a_sel = 2'd0; tick(); chk_a("dir0", 4'b1110, 2'd0, 1'b0);
      a_sel = 2'd1; tick(); chk_a("dir1", 4'b1101, 2'd1, 1'b0);
      a_sel = 2'd2; tick(); chk_a("dir2", 4'b1011, 2'd2, 1'b0);
      a_sel = 2'd3; tick(); chk_a("dir3", 4'b0111, 2'd3, 1'b0);
      a_en = 1'b0; tick(); chk_a("dir_dis", 4'b1111, 2'd3, 1'b0);
      a_en = 1'b1; tick(); chk_a("dir_reen", 4'b0111, 2'd3, 1'b0);

      // Scan from IDLE
      a_en = 1'b0; tick(); chk_a("idle", 4'b1111, 2'd3, 1'b0);
      a_en = 1'b1; a_mode = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         ea = ~(4'b0001 << (k / 3));
         chk_a("scan", ea, 2'(k / 3), 1'b0);
      end
      tick(); chk_a("scan_wrap", 4'b1110, 2'd0, 1'b1);
      tick(); chk_a("scan_postwrap", 4'b1110, 2'd0, 1'b0);
      tick(); tick(); tick(); tick();
      tick(); chk_a("scan_idx2", 4'b1011, 2'd2, 1'b0);

      // Pause at idx 2 after one dwell cycle, then resume
      a_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick(); chk_a("pause", 4'b1111, 2'd2, 1'b0);
      end
      a_en = 1'b1;
      tick(); chk_a("resume0", 4'b1011, 2'd2, 1'b0);
      tick(); chk_a("resume1", 4'b1011, 2'd2, 1'b0);
      tick(); chk_a("resume2", 4'b1011, 2'd2, 1'b0);
      tick(); chk_a("resume_adv", 4'b0111, 2'd3, 1'b0);

      // Reset mid-scan discards position
      rst = 1'b1; tick(); chk_a("midrst", 4'b1111, 2'd0, 1'b0);
      rst = 1'b0; tick(); chk_a("restart", 4'b1110, 2'd0, 1'b0);

      // SCAN -> DIRECT -> SCAN restarts at 0
      tick(); tick(); tick(); chk_a("pre_dir", 4'b1101, 2'd1, 1'b0);
      a_mode = 1'b0; a_sel = 2'd3; tick(); chk_a("to_dir", 4'b0111, 2'd3, 1'b0);
      a_mode = 1'b1; tick(); chk_a("dir_to_scan", 4'b1110, 2'd0, 1'b0);
      a_en = 1'b0;

      // DWELL=1, SEL_W=3: walk one bit per cycle
      b_en = 1'b1; b_mode = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         eb = ~(8'b0000_0001 << (k % 8));
         chk("b_walk.y", 32'(b_y), 32'(eb));
         chk("b_walk.idx", 32'(b_idx), 32'(k % 8));
         chk("b_walk.wrap", 32'(b_wrap), 32'((k > 0 && k % 8 == 0) ? 1 : 0));
      end
      b_mode = 1'b0; b_sel = 3'd5;
      tick();
      chk("b_dir.y", 32'(b_y), 32'hdf);
      chk("b_dir.idx", 32'(b_idx), 32'd5);
      chk("b_dir.wrap", 32'(b_wrap), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
